// File: rtl/uart_rx_if.sv
// Receive-side bundle of the UART link: serial line and frame config in,
// recovered word and frame status out.
interface uart_rx_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
);
    logic                      RX_IN;
    logic [PRESCALE_WIDTH-1:0] Prescale;
    logic                      PAR_EN;
    logic                      PAR_TYP;
    logic [DATA_WIDTH-1:0]     P_DATA;
    logic                      Data_Valid;
    logic                      par_err;
    logic                      stp_err;

    modport master (
        output RX_IN, Prescale, PAR_EN, PAR_TYP,
        input  P_DATA, Data_Valid, par_err, stp_err
    );

    modport slave (
        input  RX_IN, Prescale, PAR_EN, PAR_TYP,
        output P_DATA, Data_Valid, par_err, stp_err
    );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver: 2-of-3 vote at mid-bit, optional parity, one stop
// bit; exits mid-stop-bit so back-to-back frames resync on the next start edge.
module uart_rx #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input logic      CLK,
    input logic      RST,
    uart_rx_if.slave bus
);
    localparam int PW = PRESCALE_WIDTH;
    localparam int BW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

    state_e                state_q, state_d;
    logic                  rx_s1_q, rx_s2_q;
    logic [PW-1:0]         presc_q, presc_d, edge_q, edge_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic                  par_en_q, par_en_d, par_typ_q, par_typ_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d, pdata_q, pdata_d;
    logic                  smp0_q, smp0_d, smp1_q, smp1_d;
    logic                  stop_ok_q, stop_ok_d, par_bad_q, par_bad_d;
    logic                  valid_q, valid_d, par_err_q, par_err_d, stp_err_q, stp_err_d;

    logic          line, vote, at_s0, at_s1, at_s2, at_end, at_dec, frame_ok;
    logic [PW-1:0] half;

    assign line   = rx_s2_q;
    assign half   = presc_q >> 1;
    assign at_s0  = (edge_q == half - PW'(1));
    assign at_s1  = (edge_q == half);
    assign at_s2  = (edge_q == half + PW'(1));
    assign at_end = (edge_q == presc_q - PW'(1));
    // The at_end term guarantees an exit even for odd/unsupported Prescale values.
    assign at_dec = (edge_q == half + PW'(2)) || at_end;
    assign vote   = (smp0_q & smp1_q) | (smp0_q & line) | (smp1_q & line);
    assign frame_ok = stop_ok_q && !(par_en_q && par_bad_q);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
        end else begin
            rx_s1_q <= bus.RX_IN;
            rx_s2_q <= rx_s1_q;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            edge_q    <= '0;
            bit_q     <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            shift_q   <= '0;
            pdata_q   <= '0;
            smp0_q    <= 1'b1;
            smp1_q    <= 1'b1;
            stop_ok_q <= 1'b0;
            par_bad_q <= 1'b0;
            valid_q   <= 1'b0;
            par_err_q <= 1'b0;
            stp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            edge_q    <= edge_d;
            bit_q     <= bit_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            shift_q   <= shift_d;
            pdata_q   <= pdata_d;
            smp0_q    <= smp0_d;
            smp1_q    <= smp1_d;
            stop_ok_q <= stop_ok_d;
            par_bad_q <= par_bad_d;
            valid_q   <= valid_d;
            par_err_q <= par_err_d;
            stp_err_q <= stp_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        edge_d    = at_end ? '0 : edge_q + PW'(1);
        bit_d     = bit_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        shift_d   = shift_q;
        pdata_d   = pdata_q;
        smp0_d    = at_s0 ? line : smp0_q;
        smp1_d    = at_s1 ? line : smp1_q;
        stop_ok_d = stop_ok_q;
        par_bad_d = par_bad_q;
        valid_d   = 1'b0;
        par_err_d = par_err_q;
        stp_err_d = stp_err_q;

        case (state_q)
            IDLE: begin
                edge_d = '0;
                bit_d  = '0;
                if (!line) begin
                    state_d   = START;
                    presc_d   = bus.Prescale;
                    par_en_d  = bus.PAR_EN;
                    par_typ_d = bus.PAR_TYP;
                end
            end
            START: begin
                if (at_s2 && vote)
                    state_d = IDLE;
                else if (at_end)
                    state_d = DATA;
            end
            DATA: begin
                if (at_s2)
                    shift_d = {vote, shift_q[DATA_WIDTH-1:1]};
                if (at_end) begin
                    if (bit_q == BW'(DATA_WIDTH - 1)) begin
                        bit_d   = '0;
                        state_d = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            PARITY: begin
                // Odd parity expects the inverse of the data XOR.
                if (at_s2)
                    par_bad_d = vote ^ (^shift_q) ^ par_typ_q;
                if (at_end)
                    state_d = STOP;
            end
            STOP: begin
                if (at_s2)
                    stop_ok_d = vote;
                if (at_dec) begin
                    stp_err_d = !stop_ok_q;
                    par_err_d = par_en_q && par_bad_q;
                    if (frame_ok) begin
                        pdata_d = shift_q;
                        valid_d = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.P_DATA     = pdata_q;
    assign bus.Data_Valid = valid_q;
    assign bus.par_err    = par_err_q;
    assign bus.stp_err    = stp_err_q;
endmodule

// File: tb/tb_uart_rx.sv
// Directed frames into uart_rx; a scoreboard queue holds expected words and
// a monitor pops them on each Data_Valid strobe.
module tb_uart_rx;
    localparam int W  = 8;
    localparam int PW = 6;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    uart_rx_if #(.DATA_WIDTH(W), .PRESCALE_WIDTH(PW)) bus ();

    uart_rx #(.DATA_WIDTH(W), .PRESCALE_WIDTH(PW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] data;
        int           exp_cyc;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin : monitor
        exp_t e;
        int   d;
        if (RST && bus.Data_Valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got strobe with P_DATA=%0h expected none", bus.P_DATA);
            end else begin
                e = sb.pop_front();
                d = cyc - e.exp_cyc;
                chk("p_data", 32'(bus.P_DATA), 32'(e.data));
                chk("flags_on_valid", {30'd0, bus.par_err, bus.stp_err}, 32'd0);
                checks++;
                if (d < -1 || d > 1) begin
                    errors++;
                    $display("FAIL latency: got cycle %0d expected %0d +-1", cyc, e.exp_cyc);
                end
            end
        end
    end

    task automatic idle(input int n);
        bus.RX_IN = 1'b1;
        repeat (n) @(negedge CLK);
    endtask

    task automatic drive_bit(input logic b, input int p);
        bus.RX_IN = b;
        repeat (p) @(negedge CLK);
    endtask

    task automatic set_cfg(input int p, input logic pe, input logic pt);
        bus.Prescale = PW'(p);
        bus.PAR_EN   = pe;
        bus.PAR_TYP  = pt;
    endtask

    // Expected strobe cycle: 2 sync + 1 detect + whole bits + half stop bit + 2.
    task automatic send(input logic [W-1:0] d, input logic pe, input logic pbit,
                        input logic stopb, input int p, input logic expect_ok);
        exp_t e;
        if (expect_ok) begin
            e.data    = d;
            e.exp_cyc = cyc + 3 + p * (1 + W + int'(pe)) + p / 2 + 2;
            sb.push_back(e);
        end
        drive_bit(1'b0, p);
        for (int i = 0; i < W; i++) drive_bit(d[i], p);
        if (pe) drive_bit(pbit, p);
        drive_bit(stopb, p);
    endtask

    initial begin : stim
        logic [W-1:0] part;
        bus.RX_IN = 1'b1;
        set_cfg(8, 1'b0, 1'b0);
        repeat (3) @(negedge CLK);
        chk("rst_p_data", 32'(bus.P_DATA), 32'd0);
        chk("rst_valid", 32'(bus.Data_Valid), 32'd0);
        chk("rst_par_err", 32'(bus.par_err), 32'd0);
        chk("rst_stp_err", 32'(bus.stp_err), 32'd0);
        RST = 1'b1;
        idle(5);

        // 8N1 at Prescale 8
        send(8'hA5, 1'b0, 1'b0, 1'b1, 8, 1'b1);
        idle(10);
        chk("a5_pdata", 32'(bus.P_DATA), 32'hA5);

        // even parity: good then bad
        set_cfg(16, 1'b1, 1'b0);
        send(8'h3C, 1'b1, 1'b0, 1'b1, 16, 1'b1);
        send(8'h3C, 1'b1, 1'b1, 1'b1, 16, 1'b0);
        idle(10);
        chk("par_bad_par_err", 32'(bus.par_err), 32'd1);
        chk("par_bad_stp_err", 32'(bus.stp_err), 32'd0);
        chk("par_bad_pdata_hold", 32'(bus.P_DATA), 32'h3C);

        // odd parity correct, stop bit low
        set_cfg(32, 1'b1, 1'b1);
        send(8'h01, 1'b1, 1'b0, 1'b0, 32, 1'b0);
        idle(60);
        chk("frame_stp_err", 32'(bus.stp_err), 32'd1);
        chk("frame_par_err", 32'(bus.par_err), 32'd0);
        chk("frame_pdata_hold", 32'(bus.P_DATA), 32'h3C);

        // 3-cycle glitch leaves flags alone, then a good frame
        set_cfg(16, 1'b0, 1'b0);
        drive_bit(1'b0, 3);
        idle(40);
        chk("glitch_stp_err", 32'(bus.stp_err), 32'd1);
        chk("glitch_par_err", 32'(bus.par_err), 32'd0);
        send(8'h55, 1'b0, 1'b0, 1'b1, 16, 1'b1);
        idle(10);
        chk("after_glitch_stp_err", 32'(bus.stp_err), 32'd0);

        // back-to-back frames, no idle gap
        set_cfg(8, 1'b0, 1'b0);
        send(8'h00, 1'b0, 1'b0, 1'b1, 8, 1'b1);
        send(8'hFF, 1'b0, 1'b0, 1'b1, 8, 1'b1);
        send(8'h81, 1'b0, 1'b0, 1'b1, 8, 1'b1);
        idle(10);
        chk("b2b_last_pdata", 32'(bus.P_DATA), 32'h81);

        // reset in the middle of a frame's data bits
        part = 8'h5A;
        drive_bit(1'b0, 8);
        for (int i = 0; i < 4; i++) drive_bit(part[i], 8);
        RST = 1'b0;
        bus.RX_IN = 1'b1;
        @(negedge CLK);
        chk("midrst_p_data", 32'(bus.P_DATA), 32'd0);
        chk("midrst_valid", 32'(bus.Data_Valid), 32'd0);
        chk("midrst_flags", {30'd0, bus.par_err, bus.stp_err}, 32'd0);
        RST = 1'b1;
        idle(20);
        send(8'hC3, 1'b0, 1'b0, 1'b1, 8, 1'b1);
        idle(10);
        chk("post_rst_pdata", 32'(bus.P_DATA), 32'hC3);

        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge CLK);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver, the counterpart of the team's UART transmitter. It oversamples the serial line RX_IN with the system clock and detects the start bit. It recovers DATA_WIDTH data bits LSB-first, plus an optional parity bit and one stop bit. It presents the byte on P_DATA with a one-cycle Data_Valid strobe and flags parity and framing errors. It sits at the receive end of the UART link, feeding the system's register/command decoder.

Parameters:
DATA_WIDTH, 8, number of data bits per frame
PRESCALE_WIDTH, 6, width of the Prescale input

Ports:
CLK  input  1  system clock; all logic on rising edge
RST  input  1  asynchronous active-low reset
RX_IN  input  1  serial line, idle high; asynchronous to CLK
Prescale  input  PRESCALE_WIDTH  oversampling ratio, CLK cycles per bit (8, 16 or 32)
PAR_EN  input  1  1 = frame carries a parity bit
PAR_TYP  input  1  0 = even parity, 1 = odd parity
P_DATA  output  DATA_WIDTH  last correctly received data word
Data_Valid  output  1  one-cycle strobe: P_DATA updated with a good frame
par_err  output  1  parity error on most recent frame
stp_err  output  1  stop-bit (framing) error on most recent frame

Behaviour:
- Reset (RST=0, async): FSM to IDLE, counters 0, synchronizer flops 1, P_DATA=0, Data_Valid=0, par_err=0, stp_err=0.
- RX_IN passes through a 2-flop synchronizer (reset value 1). All references to "line" below mean the synchronized value.
- Prescale, PAR_EN and PAR_TYP are captured when the FSM leaves IDLE. Changes mid-frame are ignored until the next frame. Values of Prescale other than 8, 16 and 32 are unsupported. With unsupported values the FSM must still return to IDLE within one frame time.
- Counters:
  - edge_cnt runs 0..Prescale-1 within each bit, then wraps to 0 and increments bit_cnt.
  - Sample point: majority vote (2 of 3) of the line at edge_cnt = P/2-1, P/2 and P/2+1 (P = captured Prescale). The voted bit is registered at edge_cnt = P/2+1.
- FSM states:
  - IDLE: line=0 -> START with edge_cnt=0. Otherwise stay.
  - START: at the sample point, voted bit = 1 -> glitch, go to IDLE. No outputs change. Voted 0 -> at edge_cnt=P-1 go to DATA.
  - DATA: bit i is shifted into a shift register LSB-first at its sample point. After bit DATA_WIDTH-1 reaches edge_cnt=P-1, go to PARITY if PAR_EN, else STOP.
  - PARITY: at the sample point, compare the voted bit with the computed parity of the shift register. Even parity is the XOR of the data bits; odd parity is its inverse. At edge_cnt=P-1 go to STOP.
  - STOP: at the sample point, record stop_ok = voted bit. At edge_cnt=P/2+2, decide and go to IDLE. Exiting mid-stop bit lets back-to-back frames resync on the next falling edge.
- Frame result, applied on the STOP decision cycle:
  - stp_err <= !stop_ok.
  - par_err <= parity mismatch if PAR_EN, else 0.
  - If neither error: P_DATA <= shift register, and Data_Valid=1 for exactly that one cycle.
  - On any error P_DATA holds its old value and Data_Valid stays 0.
- par_err and stp_err hold until the next frame's STOP decision. A glitch-aborted start does not change them.
- Latency, Data_Valid relative to the line's start falling edge at the pin: 2 (sync) + 1 (IDLE detect) + P*(1+DATA_WIDTH+PAR_EN) + P/2+2 cycles, ±1 cycle of edge alignment.
- Line held low forever (break): the frame ends with stp_err=1. The FSM then re-enters START from IDLE and keeps reporting stp_err each frame time, with no Data_Valid.
- Reset asserted mid-frame: immediate return to reset values. A partial frame is discarded, with no Data_Valid.

Test Plan:
- Prescale=8, PAR_EN=0, send 0xA5 (8N1) -> one Data_Valid pulse, P_DATA=0xA5, par_err=0, stp_err=0, pulse within 2+1+72+6 ±1 cycles of the start edge.
- Prescale=16, PAR_EN=1, PAR_TYP=0, send 0x3C with parity 0, then 0x3C with parity 1 -> first frame: Data_Valid, P_DATA=0x3C. Second frame: par_err=1, no Data_Valid, P_DATA stays 0x3C.
- Prescale=32, PAR_EN=1, PAR_TYP=1, send 0x01 with correct odd parity (0) but stop bit 0 -> stp_err=1, par_err=0, no Data_Valid.
- Low pulse of 3 CLK cycles on idle line, Prescale=16 -> FSM returns to IDLE, no Data_Valid, error flags unchanged. A following valid 0x55 frame is received correctly.
- Back-to-back 8N1 frames 0x00, 0xFF, 0x81 with zero idle gap at Prescale=8 -> three Data_Valid pulses with P_DATA 0x00, 0xFF, 0x81 in order.
- Assert RST for 1 cycle mid-DATA of frame 0x5A, then send 0xC3 -> no pulse for 0x5A, all outputs 0 after reset, then Data_Valid with P_DATA=0xC3.
